instr_sequencer: RTL and testbench
==================================

# instr_sequencer

Program sequencer directly upstream of the ALU/register-file `top`. It fetches instruction words from a synchronous-read program memory and decodes them into `op`/`rd`/`rs1`/`rs2` fields. It issues each instruction with a one-cycle `start_cmd` pulse and waits for `cmd_done` before fetching the next. It also latches the returned Z/C flags, counts retired instructions, and traps on a missing `cmd_done` with a watchdog.

## Interface
Parameters:
- `PROG_DEPTH`, default 16: program memory words; must be a power of 2. `AW = $clog2(PROG_DEPTH)`.
- `TIMEOUT`, default 64: maximum cycles in WAIT_DONE before ERROR; must be ≥ 2.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `run`  in  1: start program from address 0; sampled in IDLE, HALTED and ERROR only.
- `abort`  in  1: return to IDLE from any state; takes priority over `run`.
- `prog_rd_en`  out  1: program memory read enable.
- `prog_addr`  out  AW: program memory address.
- `prog_data`  in  13: instruction word, valid the cycle after `prog_rd_en`.
  - `[12]` halt; `[11:9]` op; `[8:6]` rd; `[5:3]` rs1; `[2:0]` rs2.
- `start_cmd`  out  1: one-cycle issue pulse to `top`.
- `op_out`, `rd_out`, `rs1_out`, `rs2_out`  out  3 each: decoded fields.
- `cmd_done`  in  1: instruction completion from `top`.
- `z_flag_in`, `c_flag_in`  in  1: flags from `top`, valid when `cmd_done` = 1.
- `z_flag_last`, `c_flag_last`  out  1: flags of the last retired instruction.
- `pc`  out  AW: address of the current instruction.
- `instr_count`  out  8: retired instruction count, saturates at 255.
- `busy`  out  1: high in FETCH, DECODE, ISSUE and WAIT_DONE.
- `halted`  out  1: high in HALTED.
- `error`  out  1: high in ERROR.

## Operation
States: IDLE, FETCH, DECODE, ISSUE, WAIT_DONE, HALTED, ERROR.

Transitions:
- IDLE / HALTED / ERROR with `run` = 1: clear `pc`, `instr_count` and both last-flags, then go to FETCH.
- FETCH: `prog_rd_en` = 1, `prog_addr` = `pc`; go to DECODE.
- DECODE: register `prog_data` into the instruction register.
  - Halt bit = 1: go to HALTED; `pc` holds; no issue.
  - Halt bit = 0: go to ISSUE.
- ISSUE: `start_cmd` = 1; clear the watchdog; go to WAIT_DONE.
- WAIT_DONE with `cmd_done` = 1:
  - latch `z_flag_in`/`c_flag_in` into the last-flags;
  - `instr_count` += 1, saturating at 255;
  - `pc` += 1, wrapping modulo `PROG_DEPTH` (PROG_DEPTH−1 → 0);
  - go to FETCH.
- WAIT_DONE with watchdog = TIMEOUT−1 and `cmd_done` = 0: go to ERROR; `pc` holds the faulting address.
- Any state with `abort` = 1: go to IDLE next cycle. `pc`, `instr_count` and last-flags hold. `start_cmd` and `prog_rd_en` are low from that cycle on.

Field outputs:
- `op_out`/`rd_out`/`rs1_out`/`rs2_out` come from the instruction register.
- They are stable from ISSUE through the cycle `cmd_done` is sampled, and change only in DECODE.

Other rules:
- `cmd_done` is ignored outside WAIT_DONE; a stale high in ISSUE does not retire.
- `run` while `busy` is ignored.
- When `run` and `abort` are both high, `abort` wins.
- Reset values: state IDLE; every output 0, including `prog_addr`, `pc`, `instr_count`, field outputs, flags, `busy`, `halted` and `error`.
- A reset in any state, including mid-WAIT_DONE, returns to IDLE on the next edge and drops `start_cmd` at once.

## Timing
- `run` is sampled at edge k. FETCH occupies cycle k+1, DECODE k+2, and `start_cmd` is high in cycle k+3, exactly one cycle.
- When `cmd_done` is sampled high at edge d, FETCH occupies d+1 and the next `start_cmd` is at d+3.
  - Minimum issue-to-issue spacing: 4 cycles when `cmd_done` arrives one cycle after `start_cmd`.
- The watchdog counts cycles in WAIT_DONE starting at 0. ERROR is entered at the edge where the count equals TIMEOUT−1 without `cmd_done`.
  - A `cmd_done` arriving on that same edge wins: the instruction retires with no error.
- The halt instruction is reached at edge h (end of DECODE); `halted` = 1 from cycle h+1.
- `z_flag_last`, `c_flag_last`, `pc` and `instr_count` update on the edge that samples `cmd_done`.

## Test plan
- Program: [ADD 4,1,2][SUB 5,4,2][halt]; model `cmd_done` two cycles after `start_cmd`. `run` pulse produces exactly 2 `start_cmd` pulses with fields (0,4,1,2) then (1,5,4,2); ends `halted` = 1, `pc` = 2, `instr_count` = 2.
- Same model with flags returned as Z=1 on instruction 1 and C=1 on instruction 2: `z_flag_last` = 1 after the first retire; after the second, `z_flag_last` = 0 and `c_flag_last` = 1.
- `cmd_done` never asserted, TIMEOUT = 8: `error` = 1 exactly 8 cycles after `start_cmd` falls, `pc` = 0, `instr_count` = 0; a later `run` restarts from address 0.
- `cmd_done` on the final watchdog edge: instruction retires, `error` stays 0.
- `abort` in WAIT_DONE, then `rst` mid-FETCH: IDLE next cycle with `start_cmd` = 0; after reset all outputs are 0.
- `PROG_DEPTH` = 4 with no halt instruction: `prog_addr` sequence 0,1,2,3,0,1; with more than 255 retirements `instr_count` stays at 255.

Source files
------------

// File: rtl/instr_sequencer.sv
// instr_sequencer: fetches 13-bit instruction words from a synchronous-read
// program memory, decodes them into op/rd/rs1/rs2, issues each one to the
// downstream ALU with a one-cycle start_cmd pulse and waits for cmd_done.
// Retired flags and a saturating retire count are kept; a watchdog traps a
// missing cmd_done into ERROR.
module instr_sequencer #(
    parameter int PROG_DEPTH = 16,
    parameter int TIMEOUT    = 64,
    localparam int AW        = $clog2(PROG_DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    input  logic          abort,
    output logic          prog_rd_en,
    output logic [AW-1:0] prog_addr,
    input  logic [12:0]   prog_data,
    output logic          start_cmd,
    output logic [2:0]    op_out,
    output logic [2:0]    rd_out,
    output logic [2:0]    rs1_out,
    output logic [2:0]    rs2_out,
    input  logic          cmd_done,
    input  logic          z_flag_in,
    input  logic          c_flag_in,
    output logic          z_flag_last,
    output logic          c_flag_last,
    output logic [AW-1:0] pc,
    output logic [7:0]    instr_count,
    output logic          busy,
    output logic          halted,
    output logic          error
);

    localparam int WW = $clog2(TIMEOUT);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FETCH     = 3'd1;
    localparam logic [2:0] S_DECODE    = 3'd2;
    localparam logic [2:0] S_ISSUE     = 3'd3;
    localparam logic [2:0] S_WAIT_DONE = 3'd4;
    localparam logic [2:0] S_HALTED    = 3'd5;
    localparam logic [2:0] S_ERROR     = 3'd6;

    logic [2:0]    state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          z_q, z_d;
    logic          c_q, c_d;
    logic [11:0]   ir_q, ir_d;
    logic [WW-1:0] wd_q, wd_d;

    // Next-state logic: abort overrides everything, then per-state behaviour.
    // NOTE: every *_d gets a default of its *_q first so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        z_d     = z_q;
        c_d     = c_q;
        ir_d    = ir_q;
        wd_d    = wd_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_HALTED, S_ERROR: begin
                    if (run) begin
                        pc_d    = '0;
                        cnt_d   = '0;
                        z_d     = 1'b0;
                        c_d     = 1'b0;
                        state_d = S_FETCH;
                    end
                end
                S_FETCH: state_d = S_DECODE;
                S_DECODE: begin
                    ir_d    = prog_data[11:0];
                    state_d = prog_data[12] ? S_HALTED : S_ISSUE;
                end
                S_ISSUE: begin
                    wd_d    = '0;
                    state_d = S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    // cmd_done on the last watchdog cycle still retires.
                    if (cmd_done) begin
                        z_d     = z_flag_in;
                        c_d     = c_flag_in;
                        cnt_d   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                        pc_d    = pc_q + AW'(1);
                        state_d = S_FETCH;
                    end else if (wd_q == WD_LAST) begin
                        state_d = S_ERROR;
                    end else begin
                        wd_d = wd_q + WW'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State registers with synchronous reset.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            ir_q    <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            z_q     <= z_d;
            c_q     <= c_d;
            ir_q    <= ir_d;
            wd_q    <= wd_d;
        end
    end

    // Output decode; strobes are gated by abort/rst so they drop in the same
    // cycle the request arrives rather than one edge later.
    always_comb begin
        prog_rd_en  = (state_q == S_FETCH) && !abort && !rst;
        start_cmd   = (state_q == S_ISSUE) && !abort && !rst;
        prog_addr   = pc_q;
        op_out      = ir_q[11:9];
        rd_out      = ir_q[8:6];
        rs1_out     = ir_q[5:3];
        rs2_out     = ir_q[2:0];
        z_flag_last = z_q;
        c_flag_last = c_q;
        pc          = pc_q;
        instr_count = cnt_q;
        busy        = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                      (state_q == S_ISSUE) || (state_q == S_WAIT_DONE);
        halted      = (state_q == S_HALTED);
        error       = (state_q == S_ERROR);
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Testbench for instr_sequencer: program memory model, cmd_done responder
// with configurable latency, and a scoreboard of expected issued fields.
module tb_instr_sequencer;

    localparam int DEPTH = 4;
    localparam int TMO   = 8;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          rst, run, abort;
    logic          prog_rd_en;
    logic [AW-1:0] prog_addr;
    logic [12:0]   prog_data;
    logic          start_cmd;
    logic [2:0]    op_out, rd_out, rs1_out, rs2_out;
    logic          cmd_done, z_flag_in, c_flag_in;
    logic          z_flag_last, c_flag_last;
    logic [AW-1:0] pc;
    logic [7:0]    instr_count;
    logic          busy, halted, error;

    instr_sequencer #(.PROG_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .run(run), .abort(abort),
        .prog_rd_en(prog_rd_en), .prog_addr(prog_addr), .prog_data(prog_data),
        .start_cmd(start_cmd), .op_out(op_out), .rd_out(rd_out),
        .rs1_out(rs1_out), .rs2_out(rs2_out), .cmd_done(cmd_done),
        .z_flag_in(z_flag_in), .c_flag_in(c_flag_in),
        .z_flag_last(z_flag_last), .c_flag_last(c_flag_last), .pc(pc),
        .instr_count(instr_count), .busy(busy), .halted(halted), .error(error)
    );

    always #5 clk = ~clk;

    // Synchronous-read program memory.
    logic [12:0] mem [DEPTH];
    always @(posedge clk) if (prog_rd_en) prog_data <= mem[prog_addr];

    logic [30:0] outs;
    assign outs = {prog_rd_en, prog_addr, start_cmd, op_out, rd_out, rs1_out,
                   rs2_out, z_flag_last, c_flag_last, pc, instr_count, busy,
                   halted, error};

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [12:0] ins(input logic [2:0] op, rd, rs1, rs2);
        return {1'b0, op, rd, rs1, rs2};
    endfunction
    localparam logic [12:0] HALT = 13'h1000;

    // Scoreboard and retire model.
    logic [11:0]   exp_q [$];
    int            done_delay, since, ridx;
    bit            pending;
    bit            zv [8];
    bit            cv [8];
    logic          exp_z, exp_c;
    logic [7:0]    exp_cnt;
    logic [AW-1:0] exp_pc, exp_fa;

    // One clock: check the previous retire, the fetch address, any issue,
    // then drive the cmd_done responder for this cycle.
    task automatic step();
        @(posedge clk);
        #1;
        if (pending) begin
            check("ret_pc", 32'(pc), 32'(exp_pc));
            check("ret_cnt", 32'(instr_count), 32'(exp_cnt));
            check("ret_z", 32'(z_flag_last), 32'(exp_z));
            check("ret_c", 32'(c_flag_last), 32'(exp_c));
            pending = 0;
        end
        if (prog_rd_en) begin
            check("fetch_addr", 32'(prog_addr), 32'(exp_fa));
            exp_fa = exp_fa + 1'b1;
        end
        cmd_done  = 1'b0;
        z_flag_in = 1'b1;
        c_flag_in = 1'b1;
        if (start_cmd) begin
            check("issue_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0)
                check("issue_fields", 32'({op_out, rd_out, rs1_out, rs2_out}),
                      32'(exp_q.pop_front()));
            since = 0;
        end else if (since >= 0) begin
            since++;
        end
        if (since == done_delay) begin
            cmd_done  = 1'b1;
            z_flag_in = zv[ridx % 8];
            c_flag_in = cv[ridx % 8];
            exp_z     = zv[ridx % 8];
            exp_c     = cv[ridx % 8];
            ridx++;
            if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
            exp_pc  = exp_pc + 1'b1;
            since   = -1;
            pending = 1;
        end
    endtask

    // Pulse run for one edge; returns in the FETCH cycle.
    task automatic start_run();
        exp_pc = '0; exp_fa = '0; exp_cnt = '0; exp_z = 0; exp_c = 0;
        ridx = 0; since = -1;
        run = 1'b1;
        step();
        run = 1'b0;
    endtask

    task automatic run_until(input string tag, input int budget);
        int n = 0;
        while (!(halted || error) && n < budget) begin
            step();
            n++;
        end
        check({tag, "_finished"}, 32'(halted || error), 32'd1);
    endtask

    initial begin
        rst = 1; run = 0; abort = 0; cmd_done = 0; z_flag_in = 0; c_flag_in = 0;
        since = -1; pending = 0; done_delay = 1000; ridx = 0;
        exp_pc = '0; exp_fa = '0; exp_cnt = '0; exp_z = 0; exp_c = 0;
        foreach (mem[i]) mem[i] = '0;
        step();
        step();
        check("reset_outputs", 32'(outs), 32'd0);
        rst = 0;
        step();
        check("idle_outputs", 32'(outs), 32'd0);

        // Two-instruction program then halt, with per-instruction flags.
        mem[0] = ins(3'd0, 3'd4, 3'd1, 3'd2);
        mem[1] = ins(3'd1, 3'd5, 3'd4, 3'd2);
        mem[2] = HALT;
        zv[0] = 1; cv[0] = 0; zv[1] = 0; cv[1] = 1;
        done_delay = 2;
        exp_q.push_back(mem[0][11:0]);
        exp_q.push_back(mem[1][11:0]);
        start_run();
        check("busy_in_fetch", 32'(busy), 32'd1);
        step();
        check("no_issue_in_decode", 32'(start_cmd), 32'd0);
        step();
        check("issue_at_k3", 32'(start_cmd), 32'd1);
        run_until("prog1", 50);
        check("prog1_halted", 32'(halted), 32'd1);
        check("prog1_pc", 32'(pc), 32'd2);
        check("prog1_cnt", 32'(instr_count), 32'd2);
        check("prog1_z", 32'(z_flag_last), 32'd0);
        check("prog1_c", 32'(c_flag_last), 32'd1);
        check("prog1_queue_empty", 32'(exp_q.size()), 32'd0);

        // Missing cmd_done: watchdog trap after TMO cycles in WAIT_DONE.
        mem[0] = ins(3'd2, 3'd3, 3'd3, 3'd3);
        done_delay = 1000;
        exp_q.push_back(mem[0][11:0]);
        start_run();
        step();
        step();
        for (int i = 0; i < TMO; i++) begin
            step();
            check("wd_no_error_yet", 32'(error), 32'd0);
        end
        step();
        check("wd_error", 32'(error), 32'd1);
        check("wd_pc", 32'(pc), 32'd0);
        check("wd_cnt", 32'(instr_count), 32'd0);
        check("wd_not_busy", 32'(busy), 32'd0);

        // Restart from ERROR begins at address 0.
        mem[0] = ins(3'd3, 3'd1, 3'd2, 3'd3);
        mem[1] = HALT;
        done_delay = 2;
        exp_q.push_back(mem[0][11:0]);
        start_run();
        run_until("restart", 50);
        check("restart_pc", 32'(pc), 32'd1);
        check("restart_cnt", 32'(instr_count), 32'd1);
        check("restart_error_clear", 32'(error), 32'd0);

        // cmd_done on the final watchdog edge retires without error.
        mem[0] = ins(3'd4, 3'd2, 3'd2, 3'd2);
        zv[0] = 1; cv[0] = 1;
        done_delay = TMO;
        exp_q.push_back(mem[0][11:0]);
        start_run();
        run_until("last_edge", 50);
        check("last_edge_no_error", 32'(error), 32'd0);
        check("last_edge_cnt", 32'(instr_count), 32'd1);

        // Abort in ISSUE drops start_cmd in the same cycle.
        mem[0] = ins(3'd5, 3'd6, 3'd7, 3'd1);
        done_delay = 1000;
        exp_q.push_back(mem[0][11:0]);
        start_run();
        step();
        step();
        abort = 1;
        #1;
        check("abort_drops_start", 32'(start_cmd), 32'd0);
        step();
        abort = 0;
        since = -1;
        check("abort_idle", 32'(busy), 32'd0);

        // Abort in WAIT_DONE, with pc/count holding.
        exp_q.push_back(mem[0][11:0]);
        start_run();
        step(); step(); step(); step();
        abort = 1;
        step();
        abort = 0;
        since = -1;
        check("abort_wait_idle", 32'({busy, halted, error}), 32'd0);
        check("abort_hold_pc", 32'(pc), 32'd0);

        // Abort beats run.
        run = 1; abort = 1;
        step();
        run = 0; abort = 0;
        check("abort_over_run", 32'(busy), 32'd0);

        // Reset mid-FETCH.
        start_run();
        rst = 1;
        #1;
        check("rst_drops_rd_en", 32'(prog_rd_en), 32'd0);
        check("rst_start_low", 32'(start_cmd), 32'd0);
        step();
        check("rst_outputs", 32'(outs), 32'd0);
        rst = 0;
        since = -1;

        // No halt, PROG_DEPTH=4: address wrap and count saturation.
        mem[0] = ins(3'd1, 3'd1, 3'd1, 3'd1);
        mem[1] = ins(3'd2, 3'd2, 3'd2, 3'd2);
        mem[2] = ins(3'd3, 3'd3, 3'd3, 3'd3);
        mem[3] = ins(3'd4, 3'd4, 3'd4, 3'd4);
        foreach (zv[i]) begin zv[i] = i[0]; cv[i] = i[1]; end
        done_delay = 1;
        for (int i = 0; i < 300; i++) exp_q.push_back(mem[i % DEPTH][11:0]);
        start_run();
        begin
            int n = 0;
            while (ridx < 260 && n < 1500) begin
                step();
                n++;
            end
        end
        check("sat_retired", 32'(ridx), 32'd260);
        step();
        abort = 1;
        #1;
        check("abort_drops_rd_en", 32'(prog_rd_en), 32'd0);
        step();
        abort = 0;
        since = -1;
        check("sat_cnt", 32'(instr_count), 32'd255);
        check("sat_idle", 32'(busy), 32'd0);
        exp_q.delete();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
